// File: rtl/odu_chk_data_top.sv
// odu_chk_data_top: receive-side checker for the ODU data stream.
// Acquires frame/row alignment on one configurable channel, counts frames
// and alignment errors, and exposes control/status/counters on a 16-bit
// chip-select/write/output-enable config bus.
// Optional build macro: ODU_CHK_PAYLOAD_EN enables the per-beat payload
// compare and the PAYLOAD_ERR_CNT register (address 0x6).
module odu_chk_data_top #(
  parameter int CHID_W        = 7,
  parameter int DATA_W        = 384,
  parameter int ROW_BEATS_RST = 8,
  parameter int UNLOCK_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_n_cs,
  input  logic              cfg_n_we,
  input  logic              cfg_n_oe,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_din,
  output logic [15:0]       cfg_dout,
  input  logic [CHID_W-1:0] chid_in,
  input  logic [DATA_W+2:0] data_in
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PRESYNC = 2'd1,
    ST_SYNC    = 2'd2
  } state_t;

  localparam logic [7:0] RB_RST_C = 8'(ROW_BEATS_RST);
  localparam logic [7:0] UNLOCK_C = 8'(UNLOCK_FRAMES);

  // Saturating 16-bit increment for the error counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Configuration registers and write-strobe edge detector
  logic              prev_idle_r;
  logic              ctrl_en_r;
  logic [CHID_W-1:0] ctrl_chid_r;
  logic [7:0]        row_beats_r;
  logic              wr_s;
  logic              wr_ctrl_s;
  logic              clr_s;
  logic              chid_change_s;

  // Input pipeline stage
  logic              v_r;
  logic              fs_r;
  logic              rs_r;
  logic [CHID_W-1:0] chid_r;

  // Alignment tracking
  state_t            state_r;
  logic [7:0]        beat_r;
  logic [1:0]        row_r;
  logic [7:0]        consec_r;
  logic              cur_err_r;

  // Counters
  logic [15:0]       frame_cnt_r;
  logic [15:0]       row_err_cnt_r;
  logic [15:0]       frame_err_cnt_r;
  logic              sticky_r;
  logic [15:0]       cfg_dout_r;

  // Combinational decode
  logic              qual_s;
  logic              run_s;
  logic              exp_rs_s;
  logic              exp_fs_s;
  logic              row_err_s;
  logic              frm_err_s;
  logic              hdr_err_s;
  logic              pay_err_s;
  logic              sync_err_s;
  logic              last_beat_s;
  logic [7:0]        next_beat_s;
  logic [1:0]        next_row_s;
  logic [7:0]        base_s;
  logic              drop_s;
  logic              lock_s;
  logic [15:0]       rd_data_s;
  logic [15:0]       pay_rd_s;
  logic              unused_bits_s;

  assign wr_s          = !cfg_n_cs && !cfg_n_we && prev_idle_r;
  assign wr_ctrl_s     = wr_s && (cfg_addr == 4'h0);
  assign clr_s         = wr_ctrl_s && cfg_din[1];
  assign chid_change_s = wr_ctrl_s && (cfg_din[8 +: CHID_W] != ctrl_chid_r);
  assign lock_s        = (state_r == ST_SYNC);

`ifdef ODU_CHK_PAYLOAD_EN
  logic [DATA_W-1:0] payload_r;
  logic [7:0]        idx_r;
  logic [7:0]        next_idx_s;
  logic [15:0]       pay_cnt_r;

  assign pay_err_s     = (payload_r != {(DATA_W/8){idx_r}});
  assign next_idx_s    = (last_beat_s && (row_r == 2'd3)) ? 8'd0 : (idx_r + 8'd1);
  assign pay_rd_s      = pay_cnt_r;
  assign unused_bits_s = cfg_din[15];

  // Payload pipeline register, aligned with the header bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload_r <= {DATA_W{1'b0}};
    end else begin
      payload_r <= data_in[DATA_W-1:0];
    end
  end

  // Frame beat index: 1 after the aligning beat, then follows the position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= 8'd0;
    end else if (run_s && qual_s) begin
      if (state_r == ST_HUNT) begin
        idx_r <= 8'd1;
      end else begin
        idx_r <= next_idx_s;
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Payload error counter: SYNC only, saturating, clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pay_cnt_r <= 16'd0;
    end else if (clr_s) begin
      pay_cnt_r <= 16'd0;
    end else if (run_s && qual_s && (state_r == ST_SYNC) && pay_err_s) begin
      pay_cnt_r <= sat_inc(pay_cnt_r);
    end else begin
      pay_cnt_r <= pay_cnt_r;
    end
  end
`else
  assign pay_err_s     = 1'b0;
  assign pay_rd_s      = 16'd0;
  assign unused_bits_s = ^{cfg_din[15], data_in[DATA_W-1:0]};
`endif

  // Config register writes; a held strobe produces exactly one write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_idle_r <= 1'b1;
      ctrl_en_r   <= 1'b0;
      ctrl_chid_r <= {CHID_W{1'b0}};
      row_beats_r <= RB_RST_C;
    end else begin
      prev_idle_r <= cfg_n_cs | cfg_n_we;
      if (wr_ctrl_s) begin
        ctrl_en_r   <= cfg_din[0];
        ctrl_chid_r <= cfg_din[8 +: CHID_W];
      end
      if (wr_s && (cfg_addr == 4'h1)) begin
        row_beats_r <= cfg_din[7:0];
      end
    end
  end

  // One register stage on the incoming beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r    <= 1'b0;
      fs_r   <= 1'b0;
      rs_r   <= 1'b0;
      chid_r <= {CHID_W{1'b0}};
    end else begin
      v_r    <= data_in[DATA_W+2];
      fs_r   <= data_in[DATA_W+1];
      rs_r   <= data_in[DATA_W];
      chid_r <= chid_in;
    end
  end

  // Beat qualification, expected markers, next position and unlock decision
  always_comb begin
    qual_s      = v_r && (chid_r == ctrl_chid_r);
    run_s       = ctrl_en_r && (row_beats_r >= 8'd2);
    exp_rs_s    = (beat_r == 8'd0);
    exp_fs_s    = exp_rs_s && (row_r == 2'd0);
    row_err_s   = (rs_r != exp_rs_s);
    frm_err_s   = (fs_r != exp_fs_s);
    hdr_err_s   = row_err_s || frm_err_s;
    sync_err_s  = hdr_err_s || pay_err_s;
    last_beat_s = (beat_r >= (row_beats_r - 8'd1));
    if (last_beat_s) begin
      next_beat_s = 8'd0;
      next_row_s  = row_r + 2'd1;
    end else begin
      next_beat_s = beat_r + 8'd1;
      next_row_s  = row_r;
    end
    // base_s: consecutive errored frames completed before this beat's frame
    if (exp_fs_s) begin
      base_s = cur_err_r ? (consec_r + 8'd1) : 8'd0;
    end else begin
      base_s = consec_r;
    end
    // Drop lock as soon as the current frame becomes the Nth errored frame
    drop_s = sync_err_s && (exp_fs_s || !cur_err_r) && ((base_s + 8'd1) >= UNLOCK_C);
  end

  // HUNT/PRESYNC/SYNC alignment state machine with free-running position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_HUNT;
      beat_r    <= 8'd0;
      row_r     <= 2'd0;
      consec_r  <= 8'd0;
      cur_err_r <= 1'b0;
    end else if (!run_s || chid_change_s) begin
      state_r   <= ST_HUNT;
      consec_r  <= 8'd0;
      cur_err_r <= 1'b0;
    end else if (qual_s) begin
      case (state_r)
        ST_HUNT: begin
          if (fs_r && rs_r) begin
            beat_r  <= 8'd1;
            row_r   <= 2'd0;
            state_r <= ST_PRESYNC;
          end
        end
        ST_PRESYNC: begin
          beat_r <= next_beat_s;
          row_r  <= next_row_s;
          if (hdr_err_s) begin
            state_r <= ST_HUNT;
          end else if (exp_fs_s) begin
            state_r   <= ST_SYNC;
            consec_r  <= 8'd0;
            cur_err_r <= 1'b0;
          end
        end
        ST_SYNC: begin
          beat_r <= next_beat_s;
          row_r  <= next_row_s;
          if (drop_s) begin
            state_r   <= ST_HUNT;
            consec_r  <= 8'd0;
            cur_err_r <= 1'b0;
          end else begin
            consec_r  <= base_s;
            cur_err_r <= (exp_fs_s ? 1'b0 : cur_err_r) | sync_err_s;
          end
        end
        default: begin
          state_r <= ST_HUNT;
        end
      endcase
    end
  end

  // Frame and header-error counters plus sticky error; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r     <= 16'd0;
      row_err_cnt_r   <= 16'd0;
      frame_err_cnt_r <= 16'd0;
      sticky_r        <= 1'b0;
    end else if (clr_s) begin
      frame_cnt_r     <= 16'd0;
      row_err_cnt_r   <= 16'd0;
      frame_err_cnt_r <= 16'd0;
      sticky_r        <= 1'b0;
    end else if (run_s && qual_s && (state_r == ST_SYNC)) begin
      if (exp_fs_s && fs_r) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (row_err_s) begin
        row_err_cnt_r <= sat_inc(row_err_cnt_r);
      end
      if (frm_err_s) begin
        frame_err_cnt_r <= sat_inc(frame_err_cnt_r);
      end
      sticky_r <= sticky_r | sync_err_s;
    end
  end

  // Register read multiplexer
  always_comb begin
    case (cfg_addr)
      4'h0:    rd_data_s = {1'b0, ctrl_chid_r, 6'd0, 1'b0, ctrl_en_r};
      4'h1:    rd_data_s = {8'd0, row_beats_r};
      4'h2:    rd_data_s = {12'd0, 2'(state_r), sticky_r, lock_s};
      4'h3:    rd_data_s = frame_cnt_r;
      4'h4:    rd_data_s = row_err_cnt_r;
      4'h5:    rd_data_s = frame_err_cnt_r;
      4'h6:    rd_data_s = pay_rd_s;
      default: rd_data_s = 16'd0;
    endcase
  end

  // Registered read data, zero unless selected and output-enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_dout_r <= 16'd0;
    end else if (!cfg_n_cs && !cfg_n_oe) begin
      cfg_dout_r <= rd_data_s;
    end else begin
      cfg_dout_r <= 16'd0;
    end
  end

  assign cfg_dout = cfg_dout_r;

endmodule

// File: doc/odu_chk_data_top.md
# odu_chk_data_top

Receive-side checker for the ODU data stream: consumes the 387-bit `{valid, fs_start, rs_start, data[383:0]}` word and 7-bit channel ID produced by the ODU data generator. For one configurable channel it acquires frame/row alignment, counts frames and alignment errors, and exposes status and counters on the same 16-bit chip-select/write/output-enable config bus the generator uses. It sits at the sink end of loopback and bring-up test paths.

## Interface
- CHID_W, 7, channel ID width
- DATA_W, 384, payload width; `data_in` is DATA_W+3 bits
- ROW_BEATS_RST, 8, reset value of beats-per-row register
- UNLOCK_FRAMES, 3, consecutive errored frames that drop lock
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- cfg_n_cs  in  1  config chip select, active low
- cfg_n_we  in  1  config write enable, active low
- cfg_n_oe  in  1  config output enable, active low
- cfg_addr  in  4  register address
- cfg_din  in  16  write data
- cfg_dout  out  16  read data
- chid_in  in  CHID_W  channel of current beat
- data_in  in  DATA_W+3  [386] valid, [385] fs_start, [384] rs_start, [383:0] payload

## Operation
- Register map: 0x0 CTRL ([0] enable, [1] clear counters, self-clearing, [14:8] monitored chid); 0x1 ROW_BEATS ([7:0]); 0x2 STATUS ([0] lock, [1] sticky error, [3:2] state); 0x3 FRAME_CNT; 0x4 ROW_ERR_CNT; 0x5 FRAME_ERR_CNT; 0x6 PAYLOAD_ERR_CNT. Others read 0, writes ignored. STATUS and counters are read-only.
- Write: executes once on the first clk where `cs=0 && we=0` after either was high (edge-detected; held strobe = one write).
- Read: `cfg_dout` = selected register when `cs=0 && oe=0`, else 0.
- Beats counted only when valid=1 and chid_in = CTRL[14:8]. Position tracked as beat (0..ROW_BEATS-1) and row (0..3).
- Expected: rs_start=1 exactly at beat 0; fs_start=1 exactly at beat 0, row 0. Mismatch on rs_start -> row error; on fs_start -> frame error; both may count on the same beat.
- States: HUNT(0) -> on qualified beat with fs_start=1 and rs_start=1, set position to beat 1/row 0 -> PRESYNC(1). PRESYNC: any error -> HUNT; next correct frame start -> SYNC(2), lock=1. SYNC: position free-runs; errors counted; UNLOCK_FRAMES consecutive frames containing any error -> HUNT, lock=0. Position never realigns in SYNC.
- FRAME_CNT increments on each correct frame start in SYNC, wraps. Error counters count only in SYNC and saturate at 16'hFFFF. Sticky error sets on any SYNC error.
- enable=0 or ROW_BEATS<2: state forced to HUNT, counters hold. Write to CTRL changing chid forces HUNT.
- Clear and increment in the same cycle: clear wins (counters and sticky -> 0; state unaffected).

## Timing
- Reset: cfg_dout=0, CTRL=0, ROW_BEATS=ROW_BEATS_RST, state HUNT, lock=0, all counters/sticky 0.
- `data_in`/`chid_in` registered one stage; state, counters, and STATUS update 2 cycles after the beat is presented.
- `cfg_dout` registered: valid 1 cycle after cs/oe/addr settle.
- Config write takes effect the cycle after the detected strobe.
- Reset mid-frame returns immediately to reset values; next frame requires full HUNT->PRESYNC->SYNC.

## Configuration
- `ODU_CHK_PAYLOAD_EN`: defined -> in SYNC, each counted beat's payload must equal 48 copies of an 8-bit frame beat index (0 at frame start, +1 per counted beat, wraps at 255). Mismatch increments PAYLOAD_ERR_CNT (saturating) and counts as an errored frame. Undefined -> no payload compare; 0x6 reads 0.

## Test plan
- ROW_BEATS=4, chid 3, enable; 3 clean frames on chid 3 (16 beats each) -> STATUS.lock=1 after second fs_start, FRAME_CNT=1 after third, error counters 0.
- Locked, inject rs_start at beat 2 of row 1 once -> ROW_ERR_CNT=1, sticky=1, lock stays 1.
- Locked, omit fs_start on 3 consecutive frames -> FRAME_ERR_CNT=3, lock=0, state=HUNT.
- Interleave chid 5 beats with fs/rs set between chid 3 beats -> no errors, FRAME_CNT unaffected by chid 5.
- Hold cs=0/we=0 for 4 cycles writing CTRL clear while errors occur -> single write, counters 0 the next cycle, clear bit reads 0.
- With `ODU_CHK_PAYLOAD_EN`, corrupt byte 0 of beat 5 -> PAYLOAD_ERR_CNT=1; without macro -> 0x6 reads 16'h0000.
